// File: rtl/rename_pkg.sv
// Shared types and constants for the register-rename stage.
package rename_pkg;

  localparam int unsigned NUM_ARCH        = 32;
  localparam int unsigned ZERO_REG        = 31;
  localparam int unsigned ID_W            = 6;
  localparam int unsigned PRN_W           = 6;
  localparam int unsigned PRN_NUM         = 2 ** PRN_W;
  localparam int unsigned NUM_OPS         = 3;
  localparam int unsigned FREE_LIST_DEPTH = PRN_NUM - NUM_ARCH;
  localparam int unsigned FL_PTR_W        = $clog2(FREE_LIST_DEPTH);
  localparam int unsigned FL_CNT_W        = $clog2(FREE_LIST_DEPTH + 1);
  localparam int unsigned OPS_CNT_W       = $clog2(NUM_OPS + 1);

  typedef logic [4:0]       arch_reg_t;
  typedef logic [PRN_W-1:0] prn_t;

  typedef struct packed {
    logic [ID_W-1:0]    inst_id;
    logic [31:0]        raw_instr;
    logic [63:0]        pc;
    logic [NUM_OPS-1:0] src_valid;
    logic [NUM_OPS-1:0] src_ready;
    prn_t [NUM_OPS-1:0] src_prn;
    logic [NUM_OPS-1:0] dst_valid;
    prn_t [NUM_OPS-1:0] dst_prn;
    logic [NUM_OPS-1:0] prev_valid;
    prn_t [NUM_OPS-1:0] prev_prn;
  } renamed_inst_t;

  function automatic logic is_zero_reg(input arch_reg_t r);
    return r == arch_reg_t'(ZERO_REG);
  endfunction

endpackage

// File: rtl/prn_free_list.sv
// Circular FIFO of free PRNs with several push and pop ports per cycle.
module prn_free_list
  import rename_pkg::*;
#(
  parameter int unsigned PORTS = NUM_OPS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PORTS-1:0]              push_valid,
  input  prn_t                          push_prn [PORTS],
  input  logic [$clog2(PORTS+1)-1:0]    pop_count,
  output prn_t                          pop_prn [PORTS],
  output logic [FL_CNT_W-1:0]           count
);

  localparam int unsigned POP_W = $clog2(PORTS + 1);

  prn_t                  mem_q [FREE_LIST_DEPTH];
  prn_t                  mem_d [FREE_LIST_DEPTH];
  logic [FL_PTR_W-1:0]   head_q, head_d;
  logic [FL_PTR_W-1:0]   tail_q, tail_d;
  logic [FL_CNT_W-1:0]   count_q, count_d;
  logic [PRN_NUM-1:0]    free_map_q, free_map_d;
  logic                  overflow;
  logic                  underflow;
  logic                  double_free;

  function automatic logic [FL_PTR_W-1:0] wrap_inc(input logic [FL_PTR_W-1:0] p,
                                                   input int unsigned inc);
    int unsigned s;
    s = 32'(p) + inc;
    if (s >= FREE_LIST_DEPTH) s = s - FREE_LIST_DEPTH;
    return FL_PTR_W'(s);
  endfunction

  always_comb begin
    logic [FL_PTR_W-1:0] wr;
    int unsigned         npush;
    for (int unsigned k = 0; k < PORTS; k++) begin
      pop_prn[k] = mem_q[wrap_inc(head_q, k)];
    end

    mem_d       = mem_q;
    wr          = tail_q;
    npush       = 0;
    free_map_d  = free_map_q;
    double_free = 1'b0;
    for (int unsigned k = 0; k < PORTS; k++) begin
      if (k < 32'(pop_count)) free_map_d[pop_prn[k]] = 1'b0;
    end
    // Pushes are packed behind the tail in slot order; a PRN pushed this
    // cycle only becomes visible to pops through count_q next cycle.
    for (int unsigned k = 0; k < PORTS; k++) begin
      if (push_valid[k]) begin
        if (free_map_d[push_prn[k]]) double_free = 1'b1;
        free_map_d[push_prn[k]] = 1'b1;
        mem_d[wr] = push_prn[k];
        wr        = wrap_inc(wr, 1);
        npush     = npush + 1;
      end
    end
    tail_d    = wr;
    head_d    = wrap_inc(head_q, 32'(pop_count));
    count_d   = count_q + FL_CNT_W'(npush) - FL_CNT_W'(pop_count);
    overflow  = (32'(count_q) + npush) > (FREE_LIST_DEPTH + 32'(pop_count));
    underflow = 32'(pop_count) > 32'(count_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FREE_LIST_DEPTH; i++) begin
        mem_q[i] <= prn_t'(NUM_ARCH + i);
      end
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= FL_CNT_W'(FREE_LIST_DEPTH);
      for (int unsigned i = 0; i < PRN_NUM; i++) begin
        free_map_q[i] <= (i >= NUM_ARCH);
      end
    end else begin
      mem_q      <= mem_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      free_map_q <= free_map_d;
    end
  end

  assign count = count_q;

  a_no_overflow:    assert property (@(posedge clk) disable iff (!rst_n) !overflow);
  a_no_underflow:   assert property (@(posedge clk) disable iff (!rst_n) !underflow);
  a_no_double_free: assert property (@(posedge clk) disable iff (!rst_n) !double_free);

  logic unused_pop_w;
  assign unused_pop_w = ^POP_W;

endmodule

// File: rtl/rename_unit.sv
// Register-rename stage: RAT lookup, free-list allocation, ready tracking
// and a one-entry output register feeding the issue queues.
module rename_unit
  import rename_pkg::*;
#(
  parameter int unsigned INST_ID_BITS = ID_W,
  parameter int unsigned PRN_BITS     = PRN_W,
  parameter int unsigned ARCH_REGS    = NUM_ARCH,
  parameter int unsigned MAX_OPERANDS = NUM_OPS,
  parameter int unsigned FU_COUNT     = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [INST_ID_BITS-1:0] in_inst_id,
  input  logic [31:0]             in_raw_instr,
  input  logic [63:0]             in_pc,
  input  logic                    in_src_valid [MAX_OPERANDS],
  input  logic [4:0]              in_src_arch  [MAX_OPERANDS],
  input  logic                    in_dst_valid [MAX_OPERANDS],
  input  logic [4:0]              in_dst_arch  [MAX_OPERANDS],
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [INST_ID_BITS-1:0] inst_id,
  output logic [31:0]             raw_instr,
  output logic [63:0]             instr_pc,
  output logic                    prn_input_valid  [MAX_OPERANDS],
  output logic                    prn_input_ready  [MAX_OPERANDS],
  output logic [PRN_BITS-1:0]     prn_input        [MAX_OPERANDS],
  output logic                    prn_output_valid [MAX_OPERANDS],
  output logic [PRN_BITS-1:0]     prn_output       [MAX_OPERANDS],
  output logic                    prev_prn_valid   [MAX_OPERANDS],
  output logic [PRN_BITS-1:0]     prev_prn         [MAX_OPERANDS],
  input  logic                    set_prn_ready [FU_COUNT][MAX_OPERANDS],
  input  logic [PRN_BITS-1:0]     set_prn       [FU_COUNT][MAX_OPERANDS],
  input  logic                    commit_free_valid [MAX_OPERANDS],
  input  logic [PRN_BITS-1:0]     commit_free_prn   [MAX_OPERANDS]
);

  localparam int unsigned PRN_COUNT = 2 ** PRN_BITS;

  prn_t                    rat_q [ARCH_REGS];
  prn_t                    rat_d [ARCH_REGS];
  logic [PRN_COUNT-1:0]    ready_q, ready_d;
  logic [PRN_COUNT-1:0]    wake_vec;
  renamed_inst_t           out_q, out_d, nxt;
  logic                    out_valid_q, out_valid_d;

  logic [MAX_OPERANDS-1:0] dst_alloc;
  logic [OPS_CNT_W-1:0]    n_alloc;
  logic [OPS_CNT_W-1:0]    pidx;
  logic                    accept;
  logic                    dup_dst;

  logic [MAX_OPERANDS-1:0] fl_push_valid;
  prn_t                    fl_push_prn [MAX_OPERANDS];
  logic [OPS_CNT_W-1:0]    fl_pop_count;
  prn_t                    fl_pop_prn  [MAX_OPERANDS];
  logic [FL_CNT_W-1:0]     fl_count;

  prn_free_list #(
    .PORTS (MAX_OPERANDS)
  ) u_free_list (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (fl_push_valid),
    .push_prn   (fl_push_prn),
    .pop_count  (fl_pop_count),
    .pop_prn    (fl_pop_prn),
    .count      (fl_count)
  );

  always_comb begin
    for (int unsigned k = 0; k < MAX_OPERANDS; k++) begin
      fl_push_valid[k] = commit_free_valid[k];
      fl_push_prn[k]   = commit_free_prn[k];
    end
  end

  always_comb begin
    wake_vec = '0;
    for (int unsigned f = 0; f < FU_COUNT; f++) begin
      for (int unsigned m = 0; m < MAX_OPERANDS; m++) begin
        if (set_prn_ready[f][m]) wake_vec[set_prn[f][m]] = 1'b1;
      end
    end
  end

  always_comb begin
    n_alloc = '0;
    dup_dst = 1'b0;
    for (int unsigned k = 0; k < MAX_OPERANDS; k++) begin
      dst_alloc[k] = in_dst_valid[k] && !is_zero_reg(in_dst_arch[k]);
      if (dst_alloc[k]) n_alloc = n_alloc + OPS_CNT_W'(1);
    end
    for (int unsigned a = 0; a < MAX_OPERANDS; a++) begin
      for (int unsigned b = a + 1; b < MAX_OPERANDS; b++) begin
        if (dst_alloc[a] && dst_alloc[b] && in_dst_arch[a] == in_dst_arch[b]) dup_dst = 1'b1;
      end
    end

    in_ready     = (!out_valid_q || out_ready) && (fl_count >= FL_CNT_W'(n_alloc));
    accept       = in_valid && in_ready;
    fl_pop_count = accept ? n_alloc : '0;

    nxt           = '0;
    nxt.inst_id   = in_inst_id;
    nxt.raw_instr = in_raw_instr;
    nxt.pc        = in_pc;
    // Sources see the pre-update RAT; a same-cycle broadcast bypasses the table.
    for (int unsigned s = 0; s < MAX_OPERANDS; s++) begin
      if (in_src_valid[s]) begin
        if (is_zero_reg(in_src_arch[s])) begin
          nxt.src_ready[s] = 1'b1;
        end else begin
          nxt.src_valid[s] = 1'b1;
          nxt.src_prn[s]   = rat_q[in_src_arch[s]];
          nxt.src_ready[s] = ready_q[nxt.src_prn[s]] | wake_vec[nxt.src_prn[s]];
        end
      end
    end

    rat_d   = rat_q;
    ready_d = ready_q | wake_vec;
    pidx    = '0;
    for (int unsigned k = 0; k < MAX_OPERANDS; k++) begin
      if (dst_alloc[k]) begin
        nxt.dst_valid[k]  = 1'b1;
        nxt.dst_prn[k]    = fl_pop_prn[pidx];
        nxt.prev_valid[k] = 1'b1;
        nxt.prev_prn[k]   = rat_q[in_dst_arch[k]];
        if (accept) begin
          rat_d[in_dst_arch[k]]     = fl_pop_prn[pidx];
          ready_d[fl_pop_prn[pidx]] = 1'b0;
        end
        pidx = pidx + OPS_CNT_W'(1);
      end
    end

    if (accept) begin
      out_d       = nxt;
      out_valid_d = 1'b1;
    end else begin
      out_d       = out_q;
      out_valid_d = out_valid_q && !out_ready;
      for (int unsigned s = 0; s < MAX_OPERANDS; s++) begin
        if (out_q.src_valid[s] && wake_vec[out_q.src_prn[s]]) out_d.src_ready[s] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ARCH_REGS; i++) begin
        rat_q[i] <= prn_t'(i);
      end
      ready_q     <= '1;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      rat_q       <= rat_d;
      ready_q     <= ready_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    out_valid = out_valid_q;
    inst_id   = out_q.inst_id;
    raw_instr = out_q.raw_instr;
    instr_pc  = out_q.pc;
    for (int unsigned k = 0; k < MAX_OPERANDS; k++) begin
      prn_input_valid[k]  = out_q.src_valid[k];
      prn_input_ready[k]  = out_q.src_ready[k];
      prn_input[k]        = out_q.src_prn[k];
      prn_output_valid[k] = out_q.dst_valid[k];
      prn_output[k]       = out_q.dst_prn[k];
      prev_prn_valid[k]   = out_q.prev_valid[k];
      prev_prn[k]         = out_q.prev_prn[k];
    end
  end

  a_distinct_dst: assert property (@(posedge clk) disable iff (!rst_n)
                                   !(accept && dup_dst));

endmodule

// File: tb/tb_rename_unit.sv
// Directed bench for rename_unit with hand-computed expectations.
module tb_rename_unit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_inst_id;
  logic [31:0] in_raw_instr;
  logic [63:0] in_pc;
  logic       in_src_valid [3];
  logic [4:0] in_src_arch  [3];
  logic       in_dst_valid [3];
  logic [4:0] in_dst_arch  [3];
  logic       out_valid;
  logic       out_ready;
  logic [5:0] inst_id;
  logic [31:0] raw_instr;
  logic [63:0] instr_pc;
  logic       prn_input_valid  [3];
  logic       prn_input_ready  [3];
  logic [5:0] prn_input        [3];
  logic       prn_output_valid [3];
  logic [5:0] prn_output       [3];
  logic       prev_prn_valid   [3];
  logic [5:0] prev_prn         [3];
  logic       set_prn_ready [4][3];
  logic [5:0] set_prn       [4][3];
  logic       commit_free_valid [3];
  logic [5:0] commit_free_prn   [3];

  int checks = 0;
  int errors = 0;
  logic [5:0] id_cnt = 6'd1;

  rename_unit #(
    .INST_ID_BITS (6),
    .PRN_BITS     (6),
    .ARCH_REGS    (32),
    .MAX_OPERANDS (3),
    .FU_COUNT     (4)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_inst_id        (in_inst_id),
    .in_raw_instr      (in_raw_instr),
    .in_pc             (in_pc),
    .in_src_valid      (in_src_valid),
    .in_src_arch       (in_src_arch),
    .in_dst_valid      (in_dst_valid),
    .in_dst_arch       (in_dst_arch),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .inst_id           (inst_id),
    .raw_instr         (raw_instr),
    .instr_pc          (instr_pc),
    .prn_input_valid   (prn_input_valid),
    .prn_input_ready   (prn_input_ready),
    .prn_input         (prn_input),
    .prn_output_valid  (prn_output_valid),
    .prn_output        (prn_output),
    .prev_prn_valid    (prev_prn_valid),
    .prev_prn          (prev_prn),
    .set_prn_ready     (set_prn_ready),
    .set_prn           (set_prn),
    .commit_free_valid (commit_free_valid),
    .commit_free_prn   (commit_free_prn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called just after a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [2:0] sv, input logic [4:0] s0, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [2:0] dv, input logic [4:0] d0,
                      input logic [4:0] d1, input logic [4:0] d2);
    in_inst_id      = id_cnt;
    in_raw_instr    = 32'hA000_0000 | {26'h0, id_cnt};
    in_pc           = 64'h1000 + {56'h0, id_cnt, 2'b00};
    id_cnt          = id_cnt + 6'd1;
    in_src_valid[0] = sv[0]; in_src_arch[0] = s0;
    in_src_valid[1] = sv[1]; in_src_arch[1] = s1;
    in_src_valid[2] = sv[2]; in_src_arch[2] = s2;
    in_dst_valid[0] = dv[0]; in_dst_arch[0] = d0;
    in_dst_valid[1] = dv[1]; in_dst_arch[1] = d1;
    in_dst_valid[2] = dv[2]; in_dst_arch[2] = d2;
    in_valid        = 1'b1;
    #1;
    chk("send_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_inst_id = '0; in_raw_instr = '0; in_pc = '0;
    for (int i = 0; i < 3; i++) begin
      in_src_valid[i] = 1'b0; in_src_arch[i] = '0;
      in_dst_valid[i] = 1'b0; in_dst_arch[i] = '0;
      commit_free_valid[i] = 1'b0; commit_free_prn[i] = '0;
      for (int f = 0; f < 4; f++) begin
        set_prn_ready[f][i] = 1'b0; set_prn[f][i] = '0;
      end
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_prn_output0", 64'(prn_output[0]), 64'd0);
    @(negedge clk);

    // ADD X1 <- X2, X3
    send(3'b011, 5'd2, 5'd3, 5'd0, 3'b001, 5'd1, 5'd0, 5'd0);
    chk("add_out_valid", 64'(out_valid), 64'd1);
    chk("add_inst_id", 64'(inst_id), 64'd1);
    chk("add_raw", 64'(raw_instr), 64'hA000_0001);
    chk("add_pc", instr_pc, 64'h1004);
    chk("add_src0", 64'(prn_input[0]), 64'd2);
    chk("add_src1", 64'(prn_input[1]), 64'd3);
    chk("add_rdy0", 64'(prn_input_ready[0]), 64'd1);
    chk("add_rdy1", 64'(prn_input_ready[1]), 64'd1);
    chk("add_srcv2", 64'(prn_input_valid[2]), 64'd0);
    chk("add_dst0", 64'(prn_output[0]), 64'd32);
    chk("add_dstv0", 64'(prn_output_valid[0]), 64'd1);
    chk("add_prev0", 64'(prev_prn[0]), 64'd1);
    @(posedge clk); @(negedge clk);

    // X5 <- X1 held by a stalled queue; then wake PRN 32 while held
    out_ready = 1'b0;
    send(3'b001, 5'd1, 5'd0, 5'd0, 3'b001, 5'd5, 5'd0, 5'd0);
    chk("rd1_src0", 64'(prn_input[0]), 64'd32);
    chk("rd1_rdy0", 64'(prn_input_ready[0]), 64'd0);
    chk("rd1_dst0", 64'(prn_output[0]), 64'd33);
    chk("rd1_prev0", 64'(prev_prn[0]), 64'd5);
    set_prn_ready[1][0] = 1'b1; set_prn[1][0] = 6'd32;
    @(posedge clk); @(negedge clk);
    set_prn_ready[1][0] = 1'b0;
    #1;
    chk("held_rdy0", 64'(prn_input_ready[0]), 64'd1);
    chk("held_src0", 64'(prn_input[0]), 64'd32);
    chk("held_dst0", 64'(prn_output[0]), 64'd33);
    chk("held_valid", 64'(out_valid), 64'd1);
    chk("held_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("drain_valid", 64'(out_valid), 64'd0);

    // Same-cycle bypass on PRN 33; X1 now reads ready from the table
    set_prn_ready[0][2] = 1'b1; set_prn[0][2] = 6'd33;
    send(3'b011, 5'd5, 5'd1, 5'd0, 3'b000, 5'd0, 5'd0, 5'd0);
    set_prn_ready[0][2] = 1'b0;
    chk("byp_src0", 64'(prn_input[0]), 64'd33);
    chk("byp_rdy0", 64'(prn_input_ready[0]), 64'd1);
    chk("byp_rdy1", 64'(prn_input_ready[1]), 64'd1);
    chk("byp_dstv0", 64'(prn_output_valid[0]), 64'd0);

    // XZR source and destination
    send(3'b001, 5'd31, 5'd0, 5'd0, 3'b001, 5'd31, 5'd0, 5'd0);
    chk("xzr_srcv", 64'(prn_input_valid[0]), 64'd0);
    chk("xzr_rdy", 64'(prn_input_ready[0]), 64'd1);
    chk("xzr_prn", 64'(prn_input[0]), 64'd0);
    chk("xzr_dstv", 64'(prn_output_valid[0]), 64'd0);
    chk("xzr_prevv", 64'(prev_prn_valid[0]), 64'd0);

    // X4 <- X4 + X4: PRN 34 is next since XZR allocated nothing
    send(3'b011, 5'd4, 5'd4, 5'd0, 3'b001, 5'd4, 5'd0, 5'd0);
    chk("x4_src0", 64'(prn_input[0]), 64'd4);
    chk("x4_src1", 64'(prn_input[1]), 64'd4);
    chk("x4_dst0", 64'(prn_output[0]), 64'd34);
    chk("x4_prev0", 64'(prev_prn[0]), 64'd4);
    @(posedge clk); @(negedge clk);

    // Stalled X7 <- X4, then asynchronous reset
    out_ready = 1'b0;
    send(3'b001, 5'd4, 5'd0, 5'd0, 3'b001, 5'd7, 5'd0, 5'd0);
    chk("st_src0", 64'(prn_input[0]), 64'd34);
    chk("st_rdy0", 64'(prn_input_ready[0]), 64'd0);
    chk("st_dst0", 64'(prn_output[0]), 64'd35);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_dst0", 64'(prn_output[0]), 64'd0);
    chk("arst_src0", 64'(prn_input[0]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);

    // Exhaust the free list writing X10; X1 must read identity mapping
    for (int i = 0; i < 32; i++) begin
      send(3'b001, 5'd1, 5'd0, 5'd0, 3'b001, 5'd10, 5'd0, 5'd0);
      chk("fill_src0", 64'(prn_input[0]), 64'd1);
      chk("fill_rdy0", 64'(prn_input_ready[0]), 64'd1);
      chk("fill_dst0", 64'(prn_output[0]), 64'(32 + i));
      chk("fill_prev0", 64'(prev_prn[0]), (i == 0) ? 64'd10 : 64'(31 + i));
    end

    in_src_valid[0] = 1'b0;
    in_dst_valid[0] = 1'b1; in_dst_arch[0] = 5'd10;
    in_valid = 1'b1;
    #1;
    chk("full_in_ready", 64'(in_ready), 64'd0);
    in_dst_arch[0] = 5'd31;
    #1;
    chk("full_xzr_ready", 64'(in_ready), 64'd1);
    in_dst_arch[0] = 5'd10;
    commit_free_valid[0] = 1'b1; commit_free_prn[0] = 6'd5;
    #1;
    chk("commit_same_cycle", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    commit_free_valid[0] = 1'b0;
    chk("commit_next_cycle", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("realloc_valid", 64'(out_valid), 64'd1);
    chk("realloc_dst0", 64'(prn_output[0]), 64'd5);
    chk("realloc_prev0", 64'(prev_prn[0]), 64'd63);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rename_unit.md
Name: rename_unit

Overview:
- Register-rename stage directly upstream of the per-FU issue queues.
- Maps each decoded instruction's architectural source and destination registers to physical register numbers (PRNs) through a RAT, a free-list FIFO and a PRN ready table.
- Emits exactly the operand fields the issue queue consumes: prn_input_valid/ready/prn and prn_output_valid/prn.
- Recycles PRNs on commit and tracks FU wakeup broadcasts so that ready bits handed to an issue queue are never stale.

Parameters:
- INST_ID_BITS, 6, instruction ID width
- PRN_BITS, 6, PRN width; PRN_COUNT = 2**PRN_BITS
- ARCH_REGS, 32, architectural GPRs; index 31 is XZR
- MAX_OPERANDS, 3, source and destination slots per instruction
- FU_COUNT, 4, number of wakeup broadcast ports

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts the instruction this cycle
- in_inst_id  in  INST_ID_BITS  instruction ID
- in_raw_instr  in  32  raw encoding
- in_pc  in  64  program counter
- in_src_valid[MAX_OPERANDS]  in  1  source slot used
- in_src_arch[MAX_OPERANDS]  in  5  source architectural register
- in_dst_valid[MAX_OPERANDS]  in  1  destination slot used
- in_dst_arch[MAX_OPERANDS]  in  5  destination architectural register
- out_valid  out  1  renamed instruction present
- out_ready  in  1  downstream queue_ready
- inst_id / raw_instr / instr_pc  out  INST_ID_BITS/32/64  pass-through fields
- prn_input_valid[MAX_OPERANDS]  out  1  per-source valid
- prn_input_ready[MAX_OPERANDS]  out  1  per-source ready
- prn_input[MAX_OPERANDS]  out  PRN_BITS  per-source PRN
- prn_output_valid[MAX_OPERANDS]  out  1  per-destination valid
- prn_output[MAX_OPERANDS]  out  PRN_BITS  per-destination PRN
- prev_prn_valid[MAX_OPERANDS], prev_prn[MAX_OPERANDS]  out  1/PRN_BITS  old destination mapping, for the ROB
- set_prn_ready[FU_COUNT][MAX_OPERANDS]  in  1  wakeup strobe
- set_prn[FU_COUNT][MAX_OPERANDS]  in  PRN_BITS  wakeup PRN
- commit_free_valid[MAX_OPERANDS]  in  1  PRN release strobe
- commit_free_prn[MAX_OPERANDS]  in  PRN_BITS  PRN to release

Behaviour:
- Reset, applied asynchronously on rst_n low:
  - RAT[i] = i.
  - Free list holds PRNs ARCH_REGS..PRN_COUNT-1 in ascending order; count = PRN_COUNT-ARCH_REGS.
  - Ready table: all bits 1.
  - out_valid = 0; all other outputs = 0.
  - Reset mid-operation discards the held instruction; the free list is reinitialised.
- Accept condition: in_ready = (!out_valid || out_ready) && (free count >= number of valid destination slots with arch != 31).
- Latency: 1 cycle. An instruction accepted at edge N is presented at out_valid from edge N until the cycle in which out_ready is seen high.
- Sources read the RAT before this instruction's destination updates. A source equal to its own destination gets the old mapping.
- XZR handling:
  - Source arch 31: prn_input_valid = 0, prn_input = 0, prn_input_ready = 1.
  - Destination arch 31: no allocation, prn_output_valid = 0, prev_prn_valid = 0.
- Allocation:
  - Free-list pops happen in slot order (slot 0 pops first).
  - RAT[dst] <= new PRN; ready[new PRN] <= 0.
  - prev_prn = old RAT[dst].
- Valid destination arch registers within one instruction must be distinct; an assertion fires otherwise.
- Wakeup:
  - Any matching set_prn strobe sets ready[prn] <= 1.
  - Same-cycle bypass: a source whose PRN is broadcast in the accept cycle is emitted with prn_input_ready = 1.
  - While out_valid && !out_ready, a matching broadcast sets the held prn_input_ready bit, so no wakeup is lost before issue queue insertion.
- Wakeup and allocation of the same PRN in the same cycle: allocation wins (ready = 0). This case cannot occur legally.
- Commit: each commit_free_valid slot pushes its PRN to the free-list tail, in slot order, in the same cycle.
  - Simultaneous push and pop is legal; the count updates by pushes minus pops.
  - A pushed PRN is not poppable until the next cycle.
- Free-list head and tail pointers wrap modulo PRN_COUNT-ARCH_REGS.
- Overflow (push when full) and double-free are assertion failures.
- No flush support.

Decomposition:
- rename_pkg holds:
  - the constants ZERO_REG = 31 and FREE_LIST_DEPTH;
  - typedef arch_reg_t (5 bits);
  - typedef prn_t;
  - typedef renamed_inst_t (output register contents).
- Sub-module prn_free_list: a multi-push/multi-pop circular FIFO with count output and reset initialisation contents.

Test Plan:
- Reset, then ADD X1 <- X2,X3 -> prn_input = {2,3}, both ready=1; prn_output[0] = 32; prev_prn = 1; next reader of X1 gets PRN 32 with ready=0.
- Broadcast set_prn = 32 while the X1 reader is held by out_ready = 0 -> held prn_input_ready[0] rises the next cycle; output otherwise unchanged.
- Issue 32 single-destination instructions without commit -> PRNs 32..63 allocated; the 33rd sees in_ready = 0.
  - Then commit_free_prn = 5 -> next cycle in_ready = 1 and PRN 5 is allocated.
- Source and destination X31 -> prn_input_valid = 0, prn_input_ready = 1, prn_output_valid = 0; free count unchanged.
- X4 <- X4 + X4 -> sources map to the old PRN 4, destination gets a new PRN, prev_prn = 4.
- rst_n pulsed low mid-stall -> out_valid drops immediately; after release the RAT is identity and the first allocation is PRN 32.
